// File: rtl/ram_ahb_pw.sv
// rtl/ram_ahb_pw.sv - parametrised AHB-Lite RAM slave with read wait states, ERROR responses and optional posted-write buffer
// Optional feature macro: RAM_AHB_PW_WRBUF_EN (one-entry posted-write buffer, no read-after-write stall).
// The array has no reset; with PRELOAD=1 its image is placed by the loading flow, not by this RTL.
module ram_ahb_pw #(
   parameter int              DATA_WIDTH = 64,
   parameter int              PA_BITS    = 34,
   parameter longint unsigned BASE       = 0,
   parameter longint unsigned RANGE      = 65536,
   parameter int              LATENCY    = 0,
   parameter int              PRELOAD    = 0
) (
   input  logic                    HCLK,
   input  logic                    HRESET,
   input  logic                    HSEL,
   input  logic [PA_BITS-1:0]      HADDR,
   input  logic                    HWRITE,
   input  logic [1:0]              HTRANS,
   input  logic                    HREADY,
   input  logic [DATA_WIDTH-1:0]   HWDATA,
   input  logic [DATA_WIDTH/8-1:0] HWSTRB,
   output logic [DATA_WIDTH-1:0]   HRDATA,
   output logic                    HRESP,
   output logic                    HREADYOUT
);
   localparam int NB    = DATA_WIDTH / 8;
   localparam int OFFB  = $clog2(NB);
   localparam int WORDS = int'(RANGE) / NB;
   localparam int AW    = $clog2(WORDS);
   localparam logic [PA_BITS:0]   BASE_X  = (PA_BITS+1)'(BASE);
   localparam logic [PA_BITS-1:0] RANGE_A = PA_BITS'(RANGE);
   localparam logic [3:0]         LAT     = 4'(LATENCY);

   typedef enum logic [2:0] {S_IDLE, S_RDWAIT, S_RAWSTALL, S_ERR1, S_ERR2} state_t;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    hreadyout_q, hresp_q;
   logic                    dp_rd_q, dp_wr_q;
   logic [AW-1:0]           addr_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [DATA_WIDTH-1:0]   mem_q [WORDS];

   logic [PA_BITS:0]        off_x;
   logic [AW-1:0]           idx, rd_idx;
   logic                    accept, in_range, rd_accept, wr_phase, raw_hazard;
   logic                    mem_we;
   logic [AW-1:0]           mem_idx;
   logic [DATA_WIDTH-1:0]   mem_data, ram_rd, rd_out;
   logic [NB-1:0]           mem_strb;
   logic                    unused_ok;

   function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_w,
                                                         input logic [DATA_WIDTH-1:0] new_w,
                                                         input logic [NB-1:0]         strb);
      logic [DATA_WIDTH-1:0] res;
      res = old_w;
      for (int b = 0; b < NB; b++) begin
         if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
      end
      return res;
   endfunction

   // Borrow out of the subtraction flags addresses below BASE.
   assign off_x     = {1'b0, HADDR} - BASE_X;
   assign in_range  = ~off_x[PA_BITS] && (off_x[PA_BITS-1:0] < RANGE_A);
   assign idx       = off_x[OFFB +: AW];
   assign accept    = HSEL & HREADY & HTRANS[1];
   assign rd_accept = accept & ~HWRITE & in_range;
   assign wr_phase  = dp_wr_q & HREADY;
   // While a read waits, the RAM port keeps looking at the captured word.
   assign rd_idx    = ((state_q == S_RDWAIT) || (state_q == S_RAWSTALL)) ? addr_q : idx;
   assign unused_ok = ^{HTRANS[0], off_x, (PRELOAD != 0)};

`ifdef RAM_AHB_PW_WRBUF_EN
   logic                  wb_valid_q;
   logic [AW-1:0]         wb_idx_q;
   logic [DATA_WIDTH-1:0] wb_data_q;
   logic [NB-1:0]         wb_strb_q;
   logic                  rd_busy;

   assign rd_busy    = rd_accept | (state_q == S_RDWAIT) | (state_q == S_RAWSTALL);
   // Drain when the read port is free, or forcibly when a new write replaces the entry.
   assign mem_we     = wb_valid_q & (wr_phase | ~rd_busy) & ~HRESET;
   assign mem_idx    = wb_idx_q;
   assign mem_data   = wb_data_q;
   assign mem_strb   = wb_strb_q;
   assign raw_hazard = 1'b0;
   assign rd_out     = (wb_valid_q && (wb_idx_q == addr_q)) ?
                       merge_bytes(rdata_q, wb_data_q, wb_strb_q) : rdata_q;

   // Posted-write buffer: loads at the end of each write data phase, empties on drain or reset.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         wb_valid_q <= 1'b0;
      end else if (wr_phase) begin
         wb_valid_q <= 1'b1;
         wb_idx_q   <= addr_q;
         wb_data_q  <= HWDATA;
         wb_strb_q  <= HWSTRB;
      end else if (mem_we) begin
         wb_valid_q <= 1'b0;
      end
   end
`else
   assign mem_we     = wr_phase & ~HRESET;
   assign mem_idx    = addr_q;
   assign mem_data   = HWDATA;
   assign mem_strb   = HWSTRB;
   assign raw_hazard = wr_phase;
   assign rd_out     = rdata_q;
`endif

   // RAM read value; with the buffer, a drain to the word being read is forwarded.
   always_comb begin
      ram_rd = mem_q[rd_idx];
`ifdef RAM_AHB_PW_WRBUF_EN
      if (mem_we && (mem_idx == rd_idx)) ram_rd = merge_bytes(ram_rd, mem_data, mem_strb);
`endif
   end

   // Single-ported array: byte-masked write and registered read.
   always_ff @(posedge HCLK) begin
      if (mem_we) mem_q[mem_idx] <= merge_bytes(mem_q[mem_idx], mem_data, mem_strb);
      rdata_q <= ram_rd;
   end

   // Data-phase tracking and address capture, advanced only when the bus moves on.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         dp_rd_q <= 1'b0;
         dp_wr_q <= 1'b0;
      end else if (HREADY) begin
         dp_rd_q <= rd_accept;
         dp_wr_q <= accept & HWRITE & in_range;
      end
      if (accept) addr_q <= idx;
   end

   // Next-state decode for the wait/stall/error sequencer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE, S_ERR2: begin
            state_d = S_IDLE;
            if (accept && !in_range) begin
               state_d = S_ERR1;
            end else if (rd_accept) begin
               if (raw_hazard) begin
                  state_d = S_RAWSTALL;
               end else if (LAT != 4'd0) begin
                  state_d = S_RDWAIT;
                  cnt_d   = 4'd0;
               end
            end
         end
         S_RDWAIT: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == LAT) state_d = S_IDLE;
         end
         S_RAWSTALL: begin
            if (LAT != 4'd0) begin
               state_d = S_RDWAIT;
               cnt_d   = 4'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ERR1:  state_d = S_ERR2;
         default: state_d = S_IDLE;
      endcase
   end

   // State, counter and registered bus handshake outputs.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         hreadyout_q <= 1'b1;
         hresp_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hreadyout_q <= (state_d == S_IDLE) || (state_d == S_ERR2);
         hresp_q     <= (state_d == S_ERR1) || (state_d == S_ERR2);
      end
   end

   assign HREADYOUT = hreadyout_q;
   assign HRESP     = hresp_q;
   assign HRDATA    = (dp_rd_q && hreadyout_q) ? rd_out : '0;
endmodule

// File: tb/tb_ram_ahb_pw.sv
// tb/tb_ram_ahb_pw.sv - table-driven self-checking bench for ram_ahb_pw (LATENCY=3, 64-bit)
module tb_ram_ahb_pw;
   localparam logic [33:0] BASE = 34'h0_0001_0000;
`ifdef RAM_AHB_PW_WRBUF_EN
   localparam int          RAW_WAITS = 3;
   localparam logic [63:0] RST_WORD  = 64'h0123456789ABCDEF;
`else
   localparam int          RAW_WAITS = 4;
   localparam logic [63:0] RST_WORD  = 64'h0BADF00D0BADF00D;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        hsel, hwrite, hready, hresp, hreadyout;
   logic [33:0] haddr;
   logic [1:0]  htrans;
   logic [63:0] hwdata, hrdata;
   logic [7:0]  hwstrb;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      bit          wr;
      logic [33:0] addr;
      logic [63:0] wdata;
      logic [7:0]  strb;
      logic [63:0] exp_rdata;
      bit          exp_resp;
      int          exp_waits;
   } vec_t;

   vec_t vecs[15];

   ram_ahb_pw #(
      .DATA_WIDTH(64), .PA_BITS(34), .BASE(64'h10000), .RANGE(64'h1000), .LATENCY(3), .PRELOAD(0)
   ) dut (
      .HCLK(clk), .HRESET(rst), .HSEL(hsel), .HADDR(haddr), .HWRITE(hwrite), .HTRANS(htrans),
      .HREADY(hready), .HWDATA(hwdata), .HWSTRB(hwstrb), .HRDATA(hrdata), .HRESP(hresp),
      .HREADYOUT(hreadyout)
   );

   assign hready = hreadyout;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(bit wr, logic [33:0] a, logic [63:0] wd, logic [7:0] st,
                               logic [63:0] er, bit ersp, int ew);
      vec_t v;
      v.wr = wr; v.addr = a; v.wdata = wd; v.strb = st;
      v.exp_rdata = er; v.exp_resp = ersp; v.exp_waits = ew;
      return v;
   endfunction

   task automatic idle_bus();
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = '0; hwstrb = '0;
   endtask

   // One isolated transfer: address phase, then data phase until HREADYOUT.
   task automatic xfer(input bit wr, input logic [33:0] a, input logic [63:0] wd, input logic [7:0] st,
                       output logic [63:0] rd, output logic resp_first, output logic resp_last,
                       output int waits);
      hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a;
      step();
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wd; hwstrb = st;
      resp_first = hresp;
      waits = 0;
      while (hreadyout !== 1'b1 && waits < 40) begin
         chk("wait-state hrdata", hrdata, 64'h0);
         waits++;
         step();
      end
      rd = hrdata;
      resp_last = hresp;
      step();
      idle_bus();
   endtask

   // Write immediately followed by a read of the same address.
   task automatic wr_rd(input string nm, input logic [33:0] a, input logic [63:0] wd, input logic [7:0] st,
                        input logic [63:0] exp);
      int w;
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = a;
      step();
      hwdata = wd; hwstrb = st; hwrite = 1'b0;
      chk({nm, " write ready"}, 64'(hreadyout), 64'h1);
      step();
      idle_bus();
      w = 0;
      while (hreadyout !== 1'b1 && w < 40) begin
         w++;
         step();
      end
      chk({nm, " stall cycles"}, 64'(w), 64'(RAW_WAITS));
      chk({nm, " data"}, hrdata, exp);
      step();
   endtask

   initial begin
      logic [63:0] rd;
      logic        rf, rl;
      int          w;

      idle_bus();
      haddr = '0;
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      chk("reset hreadyout", 64'(hreadyout), 64'h1);
      chk("reset hresp", 64'(hresp), 64'h0);
      chk("reset hrdata", hrdata, 64'h0);
      step();
      chk("idle hreadyout", 64'(hreadyout), 64'h1);

      vecs[0]  = mk(1, BASE + 34'h000, 64'h5A5A5A5A5A5A5A5A, 8'hFF, 64'h0, 0, 0);
      vecs[1]  = mk(1, BASE + 34'h010, 64'h1122334455667788, 8'hFF, 64'h0, 0, 0);
      vecs[2]  = mk(0, BASE + 34'h010, 64'h0, 8'h00, 64'h1122334455667788, 0, 3);
      vecs[3]  = mk(1, BASE + 34'h008, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 0, 0);
      vecs[4]  = mk(1, BASE + 34'h018, 64'h0, 8'hFF, 64'h0, 0, 0);
      vecs[5]  = mk(1, BASE + 34'h018, 64'h123456789ABCDEF0, 8'hF0, 64'h0, 0, 0);
      vecs[6]  = mk(0, BASE + 34'h018, 64'h0, 8'h00, 64'h1234567800000000, 0, 3);
      vecs[7]  = mk(1, BASE + 34'hFF8, 64'hCAFEF00DBAADC0DE, 8'hFF, 64'h0, 0, 0);
      vecs[8]  = mk(0, BASE + 34'hFF8, 64'h0, 8'h00, 64'hCAFEF00DBAADC0DE, 0, 3);
      vecs[9]  = mk(0, BASE + 34'h1000, 64'h0, 8'h00, 64'h0, 1, 1);
      vecs[10] = mk(1, BASE + 34'h1000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1, 1);
      vecs[11] = mk(0, BASE - 34'h8, 64'h0, 8'h00, 64'h0, 1, 1);
      vecs[12] = mk(0, BASE + 34'h000, 64'h0, 8'h00, 64'h5A5A5A5A5A5A5A5A, 0, 3);
      vecs[13] = mk(1, BASE + 34'h030, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 0, 0);
      vecs[14] = mk(0, BASE + 34'h030, 64'h0, 8'h00, 64'h0123456789ABCDEF, 0, 3);

      for (int i = 0; i < 15; i++) begin
         xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, rf, rl, w);
         chk($sformatf("vec%0d hrdata", i), rd, vecs[i].exp_rdata);
         chk($sformatf("vec%0d waits", i), 64'(w), 64'(vecs[i].exp_waits));
         chk($sformatf("vec%0d first hresp", i), 64'(rf), 64'(vecs[i].exp_resp));
         chk($sformatf("vec%0d last hresp", i), 64'(rl), 64'(vecs[i].exp_resp));
      end

      wr_rd("raw strobe", BASE + 34'h008, 64'hAAAAAAAADEADBEEF, 8'h0F, 64'hFFFFFFFFDEADBEEF);
      wr_rd("raw full", BASE + 34'h010, 64'h8877665544332211, 8'hFF, 64'h8877665544332211);

      // IDLE transfer with HSEL high: zero-wait OKAY and no RAM write.
      hsel = 1'b1; htrans = 2'b00; hwrite = 1'b1; haddr = BASE + 34'h010;
      step();
      idle_bus();
      hwdata = 64'hFFFFFFFFFFFFFFFF; hwstrb = 8'hFF;
      chk("idle-xfer hreadyout", 64'(hreadyout), 64'h1);
      chk("idle-xfer hresp", 64'(hresp), 64'h0);
      step();
      idle_bus();
      xfer(0, BASE + 34'h010, 64'h0, 8'h00, rd, rf, rl, w);
      chk("idle-xfer no write", rd, 64'h8877665544332211);

      // Write to 0x30 then a read of 0x08 in its data phase; reset lands during the read wait.
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = BASE + 34'h030;
      step();
      hwdata = 64'h0BADF00D0BADF00D; hwstrb = 8'hFF; hwrite = 1'b0; haddr = BASE + 34'h008;
      step();
      idle_bus();
      chk("pre-reset stalled", 64'(hreadyout), 64'h0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid-reset hreadyout", 64'(hreadyout), 64'h1);
      chk("mid-reset hresp", 64'(hresp), 64'h0);
      chk("mid-reset hrdata", hrdata, 64'h0);
      step();
      chk("post-reset hreadyout", 64'(hreadyout), 64'h1);
      xfer(0, BASE + 34'h030, 64'h0, 8'h00, rd, rf, rl, w);
      chk("post-reset word 0x30", rd, RST_WORD);
      chk("post-reset waits", 64'(w), 64'h3);
      xfer(0, BASE + 34'h008, 64'h0, 8'h00, rd, rf, rl, w);
      chk("post-reset word 0x08", rd, 64'hFFFFFFFFDEADBEEF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ram_ahb_pw.md
# ram_ahb_pw

Parametrised single-ported on-chip AHB-Lite RAM slave for the uncore. Generalises the existing zero-latency AHB RAM with configurable data width and depth, programmable read wait states, out-of-range ERROR responses, and an optional posted-write buffer that removes the read-after-write stall. It sits on the AHB fabric behind the address decoder, alongside the other uncore slaves.

## Interface
Parameters:
- DATA_WIDTH, 64: bus and RAM word width in bits; 32 or 64.
- PA_BITS, 34: physical address width.
- BASE, 0: byte base address of the region.
- RANGE, 65536: region size in bytes; a power of two and a multiple of DATA_WIDTH/8.
- LATENCY, 0: extra read wait states, 0..15.
- PRELOAD, 0: when 1, the RAM array is initialised from a memory file.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  PA_BITS  byte address, address phase.
- HWRITE  in  1  1 = write.
- HTRANS  in  2  transfer type; bit 1 set = NONSEQ/SEQ.
- HREADY  in  1  bus-level ready; the previous transfer completes.
- HWDATA  in  DATA_WIDTH  write data, data phase.
- HWSTRB  in  DATA_WIDTH/8  byte write enables, data phase.
- HRDATA  out  DATA_WIDTH  read data.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HREADYOUT  out  1  slave ready.

## Operation
- A transfer is accepted when HSEL & HREADY & HTRANS[1]. The block captures the address and direction. IDLE and BUSY transfers get a zero-wait OKAY and cause no RAM access.
- Word index = (HADDR − BASE) >> log2(DATA_WIDTH/8), truncated to log2(RANGE·8/DATA_WIDTH) bits.
- Out of range (HADDR < BASE or HADDR ≥ BASE+RANGE):
  - The RAM is not accessed.
  - Two-cycle ERROR response: ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1).
- Write: the write is performed in the data phase using the captured address, HWDATA and HWSTRB. No wait states.
- Read:
  - The RAM read launches in the address phase from the live HADDR.
  - During wait states, the captured address is held on the RAM port.
- State machine states: IDLE, RDWAIT, RAWSTALL, ERR1, ERR2.
  - IDLE → RDWAIT: accepted read with LATENCY>0.
  - IDLE → RAWSTALL: read accepted during a write data phase (non-bypass build only).
  - IDLE → ERR1: accepted out-of-range transfer.
  - RDWAIT → IDLE: when the counter reaches LATENCY.
  - RAWSTALL → RDWAIT or IDLE: after the single stall cycle, depending on LATENCY.
  - ERR1 → ERR2 → IDLE.
- The wait counter is 4 bits. It clears on entry to RDWAIT and increments each cycle in RDWAIT.
- HRDATA is 0 in every cycle except a read data-phase cycle with HREADYOUT=1.
- HRESET in any state:
  - State returns to IDLE.
  - Counter clears.
  - The posted write, if any, is discarded.
  - RAM contents are preserved.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0.
- Read accepted at cycle n: HREADYOUT=0 for cycles n+1 … n+LATENCY. Data is valid with HREADYOUT=1 at cycle n+1+LATENCY.
- Write accepted at cycle n: HWDATA is sampled at cycle n+1 with HREADYOUT=1, and the RAM is updated at the end of n+1.
- Back-to-back reads with LATENCY=0 run at one per cycle.
- Read-after-write timing depends on RAM_AHB_PW_WRBUF_EN (see Configuration).

## Configuration
Macro `RAM_AHB_PW_WRBUF_EN`.

Defined:
- A one-entry posted-write buffer (address, data, strobe, valid) loads at the end of every write data phase.
- The buffered write drains to the RAM in the next cycle in which no read is launching or waiting. A new write into a full buffer drains the old entry in the same cycle.
- A read whose word index matches a valid buffer entry gets the buffer bytes (per strobe) merged over the RAM data.
- A read after a write never stalls.

Undefined:
- Writes go straight to the RAM.
- A read accepted during a write data phase enters RAWSTALL: one extra HREADYOUT=0 cycle, then the read launches from the captured address.

## Test plan
- Reset, then idle → HREADYOUT=1, HRESP=0, HRDATA=0.
- Write 0x1122334455667788 to BASE+0x10 with HWSTRB=0xFF, then read BASE+0x10 with LATENCY=3 → three HREADYOUT=0 cycles, then HRDATA=0x1122334455667788. Also check the single stall cycle without WRBUF and none with it.
- Write BASE+0x8 with HWSTRB=0x0F, data 0xAAAAAAAA_DEADBEEF, over prior 0xFFFFFFFFFFFFFFFF, immediately followed by a read of BASE+0x8 → 0xFFFFFFFFDEADBEEF in both builds.
- Read BASE+RANGE → ERR1 then ERR2 with HRESP=1, and the RAM is unchanged. The next valid read completes normally.
- Assert HRESET during RDWAIT, and with a posted write pending (WRBUF build) → outputs return to reset values, and the discarded write leaves the old word contents.
- HTRANS=IDLE with HSEL=1 → zero-wait OKAY, no RAM write.
